// File: rtl/mcu_cmd_mc.sv
// Multi-channel MCU SPI command decoder: per-channel address pointers with wrap masks,
// handshaked read/write requests and SD-DMA auto-increment. MCU_CMD_CRC_EN adds a write CRC-8 (0xF2).
module mcu_cmd_mc #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 24,
  parameter int CH_W   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_ready,
  input  logic                     param_ready,
  input  logic [7:0]               cmd_data,
  input  logic [7:0]               param_data,
  input  logic [31:0]              spi_byte_cnt,
  output logic [7:0]               spi_data_out,
  output logic                     mcu_rrq,
  output logic                     mcu_wrq,
  input  logic                     mcu_rq_rdy,
  input  logic [7:0]               mcu_data_in,
  output logic [7:0]               mcu_data_out,
  output logic [CH_W-1:0]          mcu_ch,
  output logic [NUM_CH*ADDR_W-1:0] addr_out,
  input  logic [NUM_CH-1:0]        dma_nextaddr
);
  localparam int          AB  = (ADDR_W + 7) / 8;
  localparam int          WB  = AB * 8;
  localparam int unsigned NCH = NUM_CH;
  localparam int unsigned ABU = AB;

  logic [ADDR_W-1:0] r_ptr      [NUM_CH];
  logic [ADDR_W-1:0] r_mask     [NUM_CH];
  logic [ADDR_W-1:0] w_ptr_nxt  [NUM_CH];
  logic [ADDR_W-1:0] w_mask_nxt [NUM_CH];
  logic              r_busy, r_ovr, r_rd, r_rdy_q;
  logic [7:0]        w_crc;
  logic [3:0]        w_op, w_n;
  logic [31:0]       w_pos;
  logic              w_ch_ok, w_byte, w_done, w_prm_in;
  logic              w_ld_ptr, w_ld_mask, w_rd_trig, w_wr_trig, w_accept, w_drop;

  // Byte pos counts down from the MSB byte; the first parameter byte zeroes the rest.
  function automatic logic [ADDR_W-1:0] f_load(input logic [ADDR_W-1:0] old, input logic first,
                                               input logic [31:0] pos, input logic [7:0] d);
    logic [WB-1:0] w;
    w = first ? '0 : WB'(old);
    for (int unsigned b = 0; b < ABU; b++)
      if (pos == b) w[b*8 +: 8] = d;
    return w[ADDR_W-1:0];
  endfunction

  function automatic logic [ADDR_W-1:0] f_inc(input logic [ADDR_W-1:0] p, input logic [ADDR_W-1:0] m,
                                              input logic [1:0] k);
    return (p & ~m) | ((p + ADDR_W'(k)) & m);
  endfunction

  assign w_op      = cmd_data[7:4];
  assign w_n       = cmd_data[3:0];
  assign w_ch_ok   = (32'(w_n) < 32'(NUM_CH));
  assign w_byte    = cmd_ready | param_ready;
  assign w_done    = mcu_rq_rdy & ~r_rdy_q & r_busy;
  assign w_pos     = 32'(AB + 1) - spi_byte_cnt;
  assign w_prm_in  = param_ready && (spi_byte_cnt >= 32'd2) && (spi_byte_cnt <= 32'(AB + 1));
  assign w_ld_ptr  = w_prm_in && w_ch_ok && (w_op == 4'h0);
  assign w_ld_mask = w_prm_in && w_ch_ok && (w_op == 4'h1);
  assign w_rd_trig = w_ch_ok && (w_op == 4'h8) && w_byte;
  assign w_wr_trig = w_ch_ok && (w_op == 4'h9) && param_ready;
  assign w_accept  = (w_rd_trig | w_wr_trig) & ~r_busy;
  assign w_drop    = (w_rd_trig | w_wr_trig) & r_busy;

  // MCU completion and DMA strobe on one channel add up to a step of 2; a load overrides both.
  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      w_ptr_nxt[i]  = f_inc(r_ptr[i], r_mask[i],
                            {1'b0, w_done && (32'(mcu_ch) == i)} + {1'b0, dma_nextaddr[i]});
      w_mask_nxt[i] = r_mask[i];
      if (w_ld_ptr && (32'(w_n) == i))
        w_ptr_nxt[i] = f_load(r_ptr[i], spi_byte_cnt == 32'd2, w_pos, param_data);
      if (w_ld_mask && (32'(w_n) == i))
        w_mask_nxt[i] = f_load(r_mask[i], spi_byte_cnt == 32'd2, w_pos, param_data);
    end
  end

  always_comb begin
    addr_out = '0;
    for (int unsigned i = 0; i < NCH; i++)
      addr_out[i*ADDR_W +: ADDR_W] = r_ptr[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        r_ptr[i]  <= '0;
        r_mask[i] <= '1;
      end
      spi_data_out <= '0;
      mcu_data_out <= '0;
      mcu_ch       <= '0;
      mcu_rrq      <= 1'b0;
      mcu_wrq      <= 1'b0;
      r_busy       <= 1'b0;
      r_ovr        <= 1'b0;
      r_rd         <= 1'b0;
      r_rdy_q      <= 1'b0;
    end else begin
      r_rdy_q <= mcu_rq_rdy;
      for (int unsigned i = 0; i < NCH; i++) begin
        r_ptr[i]  <= w_ptr_nxt[i];
        r_mask[i] <= w_mask_nxt[i];
      end
      mcu_rrq <= w_accept & w_rd_trig;
      mcu_wrq <= w_accept & w_wr_trig;
      if (w_done) r_busy <= 1'b0;
      if (w_accept) begin
        r_busy <= 1'b1;
        r_rd   <= w_rd_trig;
        mcu_ch <= CH_W'(w_n);
      end
      if (w_wr_trig) mcu_data_out <= param_data;
      if (w_byte && (cmd_data == 8'hF1)) r_ovr <= 1'b0;
      if (w_drop) r_ovr <= 1'b1;
      if (w_byte) begin
        case (cmd_data)
          8'hF0:   spi_data_out <= 8'hA5;
          8'hF1:   spi_data_out <= {r_ovr, r_busy, 6'b0};
          8'hF2:   spi_data_out <= w_crc;
          default: ;
        endcase
      end
      if (w_done && r_rd) spi_data_out <= mcu_data_in;
    end
  end

`ifdef MCU_CMD_CRC_EN
  logic [7:0] r_crc;

  function automatic logic [7:0] f_crc8(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] x;
    x = c ^ d;
    for (int unsigned b = 0; b < 8; b++)
      x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
    return x;
  endfunction

  always_ff @(posedge clk) begin
    if (rst)
      r_crc <= '0;
    else if (cmd_ready && w_ch_ok && (w_op == 4'h9))
      r_crc <= '0;
    else if (w_accept && w_wr_trig)
      r_crc <= f_crc8(r_crc, param_data);
  end

  assign w_crc = r_crc;
`else
  assign w_crc = '0;
`endif

endmodule

// File: tb/tb_mcu_cmd_mc.sv
// Randomized bench for mcu_cmd_mc against a transaction-level reference model,
// preceded by directed load/wrap/read/write/overrun/DMA/CRC scenarios.
module tb_mcu_cmd_mc;
  localparam int          NCH = 4;
  localparam int          AW  = 24;
  localparam int unsigned AB  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_ready, param_ready, mcu_rq_rdy;
  logic [7:0]        cmd_data, param_data, mcu_data_in;
  logic [31:0]       spi_byte_cnt;
  logic [7:0]        spi_data_out, mcu_data_out;
  logic              mcu_rrq, mcu_wrq;
  logic [1:0]        mcu_ch;
  logic [NCH*AW-1:0] addr_out;
  logic [NCH-1:0]    dma_nextaddr;

  mcu_cmd_mc #(.NUM_CH(NCH), .ADDR_W(AW), .CH_W(2)) dut (
    .clk(clk), .rst(rst), .cmd_ready(cmd_ready), .param_ready(param_ready),
    .cmd_data(cmd_data), .param_data(param_data), .spi_byte_cnt(spi_byte_cnt),
    .spi_data_out(spi_data_out), .mcu_rrq(mcu_rrq), .mcu_wrq(mcu_wrq),
    .mcu_rq_rdy(mcu_rq_rdy), .mcu_data_in(mcu_data_in), .mcu_data_out(mcu_data_out),
    .mcu_ch(mcu_ch), .addr_out(addr_out), .dma_nextaddr(dma_nextaddr)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  logic [23:0] m_ptr [NCH];
  logic [23:0] m_mask[NCH];
  logic        m_busy, m_isrd, m_ovr, m_rdy_prev, e_rrq, e_wrq;
  logic [1:0]  m_ch;
  logic [7:0]  m_spi, m_dout, m_crc;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] m_inc(input logic [23:0] p, input logic [23:0] m, input int unsigned k);
    return (p & ~m) | ((p + 24'(k)) & m);
  endfunction

  function automatic logic [23:0] m_load(input logic [23:0] old, input int unsigned bc, input logic [7:0] d);
    int unsigned sh;
    logic [23:0] v;
    sh = (AB + 1 - bc) * 8;
    v  = (bc == 2) ? 24'h0 : old;
    return (v & ~(24'hFF << sh)) | (24'(d) << sh);
  endfunction

  // Remainder of (crc^d)*x^8 modulo x^8+x^2+x+1.
  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
    logic [15:0] v;
    v = {c ^ d, 8'h00};
    for (int b = 15; b >= 8; b--)
      if (v[b]) v = v ^ (16'h0107 << (b - 8));
    return v[7:0];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_ptr[i]  = 24'h0;
      m_mask[i] = 24'hFFFFFF;
    end
    m_busy = 0; m_isrd = 0; m_ovr = 0; m_rdy_prev = 0; e_rrq = 0; e_wrq = 0;
    m_ch = 0; m_spi = 0; m_dout = 0; m_crc = 0;
  endtask

  task automatic compare_all();
    logic [95:0] ea;
    for (int i = 0; i < NCH; i++) ea[i*24 +: 24] = m_ptr[i];
    chk("addr_out", 96'(addr_out), ea);
    chk("spi_data_out", 96'(spi_data_out), 96'(m_spi));
    chk("mcu_data_out", 96'(mcu_data_out), 96'(m_dout));
    chk("mcu_rrq", 96'(mcu_rrq), 96'(e_rrq));
    chk("mcu_wrq", 96'(mcu_wrq), 96'(e_wrq));
    chk("mcu_ch", 96'(mcu_ch), 96'(m_ch));
  endtask

  task automatic cyc(input logic cr, input logic pr, input int unsigned bc, input logic [7:0] pd,
                     input logic rdy, input logic [7:0] rdat, input logic [NCH-1:0] dma);
    int unsigned n, op, kk[NCH];
    logic edg, busy0, byt, chok, rd, wr, ld;
    cmd_ready = cr; param_ready = pr; spi_byte_cnt = bc; param_data = pd;
    mcu_rq_rdy = rdy; mcu_data_in = rdat; dma_nextaddr = dma;
    n = cmd_data[3:0]; op = cmd_data[7:4]; chok = (n < NCH);
    edg = rdy && !m_rdy_prev; m_rdy_prev = rdy;
    busy0 = m_busy; byt = cr || pr;
    e_rrq = 0; e_wrq = 0;
    for (int i = 0; i < NCH; i++) kk[i] = dma[i];
    if (edg && busy0) begin
      kk[m_ch]++;
      m_busy = 0;
    end
    if (byt) begin
      if (cmd_data == 8'hF0) m_spi = 8'hA5;
      if (cmd_data == 8'hF1) begin m_spi = {m_ovr, busy0, 6'b0}; m_ovr = 0; end
`ifdef MCU_CMD_CRC_EN
      if (cmd_data == 8'hF2) m_spi = m_crc;
`else
      if (cmd_data == 8'hF2) m_spi = 8'h00;
`endif
    end
    if (edg && busy0 && m_isrd) m_spi = rdat;
    rd = chok && op == 8 && byt;
    wr = chok && op == 9 && pr;
    if (chok && op == 9 && cr) m_crc = 0;
    if (wr) m_dout = pd;
    if (rd || wr) begin
      if (busy0) m_ovr = 1;
      else begin
        m_busy = 1; m_isrd = rd; m_ch = 2'(n); e_rrq = rd; e_wrq = wr;
        if (wr) m_crc = crc8(m_crc, pd);
      end
    end
    ld = pr && chok && bc >= 2 && bc <= AB + 1;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (ld && op == 0 && n == i) m_ptr[i] = m_load(m_ptr[i], bc, pd);
      else if (kk[i] != 0)         m_ptr[i] = m_inc(m_ptr[i], m_mask[i], kk[i]);
    end
    for (int unsigned i = 0; i < NCH; i++)
      if (ld && op == 1 && n == i) m_mask[i] = m_load(m_mask[i], bc, pd);
    @(posedge clk); #1;
    compare_all();
    cmd_ready = 0; param_ready = 0; dma_nextaddr = '0;
  endtask

  task automatic idle();                                          cyc(0, 0, 0, 0, 0, 0, 0); endtask
  task automatic do_cmd(input logic [7:0] c);                     cmd_data = c; cyc(1, 0, 1, 0, 0, 0, 0); endtask
  task automatic do_prm(input int unsigned bc, input logic [7:0] d); cyc(0, 1, bc, d, 0, 0, 0); endtask
  task automatic do_rdy(input logic [7:0] d);                     cyc(0, 0, 0, 0, 1, d, 0); idle(); endtask

  task automatic load3(input logic [7:0] c, input logic [7:0] a, input logic [7:0] b, input logic [7:0] d);
    do_cmd(c); do_prm(2, a); do_prm(3, b); do_prm(4, d);
  endtask

  task automatic rcyc(input logic cr, input logic pr, input int unsigned bc, input logic [7:0] pd);
    logic r;
    logic [NCH-1:0] dm;
    r = ($urandom_range(0, 2) == 0);
    if ((cr || pr) && cmd_data[7:4] == 4'hF) r = m_rdy_prev;
    dm = ($urandom_range(0, 4) == 0) ? NCH'($urandom) : '0;
    cyc(cr, pr, bc, pd, r, 8'($urandom), dm);
  endtask

  initial begin
    logic [7:0] c;
    int unsigned sel, ch, nb;
    rst = 1; cmd_ready = 0; param_ready = 0; cmd_data = 0; param_data = 0;
    spi_byte_cnt = 0; mcu_rq_rdy = 0; mcu_data_in = 0; dma_nextaddr = '0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    compare_all();
    rst = 0;

    load3(8'h02, 8'h12, 8'h34, 8'h56);
    do_prm(5, 8'hEE);
    chk("load_ch2", 96'(addr_out[71:48]), 96'h123456);
    chk("load_others", 96'({addr_out[95:72], addr_out[47:0]}), 96'h0);
    load3(8'h07, 8'hAA, 8'hBB, 8'hCC);
    chk("bad_ch_ignored", 96'(addr_out), 96'h000000_123456_000000_000000);

    load3(8'h11, 8'h00, 8'h00, 8'hFF);
    load3(8'h01, 8'h00, 8'h12, 8'hFF);
    do_cmd(8'h81);
    do_rdy(8'h00);
    chk("wrap_ch1", 96'(addr_out[47:24]), 96'h001200);

    load3(8'h00, 8'h00, 8'h00, 8'h10);
    do_cmd(8'h80);
    chk("rd_rrq", 96'(mcu_rrq), 96'h1);
    chk("rd_ch", 96'(mcu_ch), 96'h0);
    idle();
    chk("rd_rrq_1cyc", 96'(mcu_rrq), 96'h0);
    do_rdy(8'h5A);
    chk("rd_data", 96'(spi_data_out), 96'h5A);
    chk("rd_inc", 96'(addr_out[23:0]), 96'h000011);

    do_cmd(8'h90); do_prm(2, 8'hAA); do_prm(3, 8'hBB);
    chk("wr_data", 96'(mcu_data_out), 96'hBB);
    do_cmd(8'hF1);
    chk("status_busy_ovr", 96'(spi_data_out), 96'hC0);
    do_rdy(8'h00);
    do_cmd(8'hF1);
    chk("status_clear", 96'(spi_data_out), 96'h00);
    do_cmd(8'h90); do_prm(2, 8'h01); do_prm(3, 8'h02);
    do_rdy(8'h00);
    do_cmd(8'hF1);
    chk("status_ovr_only", 96'(spi_data_out), 96'h80);
    do_cmd(8'hF0);
    chk("magic", 96'(spi_data_out), 96'hA5);

    load3(8'h00, 8'h00, 8'h00, 8'hFE);
    do_cmd(8'h80);
    cyc(0, 0, 0, 0, 1, 8'h11, 4'b0001);
    idle();
    chk("dma_plus_rdy", 96'(addr_out[23:0]), 96'h000100);
    do_cmd(8'h00); do_prm(2, 8'h00); do_prm(3, 8'h00);
    cyc(0, 1, 4, 8'h40, 0, 0, 4'b0001);
    chk("load_beats_dma", 96'(addr_out[23:0]), 96'h000040);

    do_cmd(8'h93);
    for (int unsigned k = 0; k < 9; k++) begin
      do_prm(2 + k, 8'(8'h31 + k));
      do_rdy(8'h00);
    end
    do_cmd(8'hF2);
`ifdef MCU_CMD_CRC_EN
    chk("crc_check", 96'(spi_data_out), 96'hF4);
`else
    chk("crc_absent", 96'(spi_data_out), 96'h00);
`endif

    do_cmd(8'h82);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    compare_all();
    do_rdy(8'h77);
    chk("rdy_after_reset", 96'(spi_data_out), 96'h00);

    repeat (300) begin
      sel = $urandom_range(0, 9);
      ch  = $urandom_range(0, 5);
      case (sel)
        0:       c = {4'h0, 4'(ch)};
        1:       c = {4'h1, 4'(ch)};
        2, 3:    c = {4'h8, 4'(ch)};
        4, 5:    c = {4'h9, 4'(ch)};
        6:       c = 8'hF0;
        7:       c = 8'hF1;
        8:       c = 8'hF2;
        default: c = 8'($urandom);
      endcase
      cmd_data = c;
      rcyc(1, 0, 1, 0);
      nb = $urandom_range(0, 5);
      for (int unsigned b = 0; b < nb; b++) begin
        if ($urandom_range(0, 1) == 1) rcyc(0, 0, 0, 0);
        rcyc(0, 1, 2 + b, 8'($urandom));
      end
      repeat ($urandom_range(0, 2)) rcyc(0, 0, 0, 0);
    end

    repeat (3) idle();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
